bms_cell_scan_sched: RTL

Periodic cell-voltage scan scheduler for the battery management subsystem. It steps an analog cell multiplexer across all series cells, sequences one ADC conversion per cell with a start/done handshake, and compares each result against programmable limits. At the end of every scan it publishes the aggregated `ov_raw`/`uv_raw` flags and min/max cell voltages. Those flags feed the BMS fault FSM's raw overvoltage/undervoltage inputs.

---
 rtl/bms_cell_scan_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bms_cell_scan_sched.sv
// Periodic cell-voltage scan scheduler: steps the cell mux, runs one ADC
// conversion per cell and publishes per-scan OV/UV flags and min/max readings.
module bms_cell_scan_sched #(
  parameter int N_CELLS     = 8,
  parameter int ADC_W       = 12,
  parameter int SETTLE      = 4,
  parameter int SCAN_PERIOD = 1000,
  parameter int ADC_TMO     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scan_en,
  input  logic [ADC_W-1:0]           ov_th,
  input  logic [ADC_W-1:0]           uv_th,
  output logic [$clog2(N_CELLS)-1:0] mux_sel,
  output logic                       adc_start,
  input  logic                       adc_done,
  input  logic [ADC_W-1:0]           adc_data,
  output logic                       ov_raw,
  output logic                       uv_raw,
  output logic [ADC_W-1:0]           min_v,
  output logic [ADC_W-1:0]           max_v,
  output logic                       scan_done,
  output logic                       adc_err,
  output logic                       overrun
);

  localparam int CW = $clog2(N_CELLS);
  localparam int TW = $clog2(SCAN_PERIOD);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int WW = $clog2(ADC_TMO + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SCAN_PERIOD - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);
  localparam logic [WW-1:0] W_LAST = WW'(ADC_TMO - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_CELLS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_CONV, ST_WAIT, ST_DONE} state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic             tick;
  logic [CW-1:0]    idx;
  logic [SW-1:0]    scnt;
  logic [WW-1:0]    tcnt;
  logic [ADC_W-1:0] ov_lim, uv_lim;
  logic             ov_acc, uv_acc;
  logic [ADC_W-1:0] min_acc, max_acc;
  logic             tmo_hit, step;
  logic             ov_nx, uv_nx;
  logic [ADC_W-1:0] min_nx, max_nx;

  assign tick = scan_en && (timer == T_LAST);

  // Accumulator values after the current WAIT cycle; a strobe on the last
  // allowed cycle beats the timeout, and a timeout flags the cell both ways.
  always_comb begin
    tmo_hit = !adc_done && (tcnt == W_LAST);
    step    = adc_done || tmo_hit;
    ov_nx   = ov_acc | tmo_hit | (adc_done && (adc_data > ov_lim));
    uv_nx   = uv_acc | tmo_hit | (adc_done && (adc_data < uv_lim));
    min_nx  = (adc_done && (adc_data < min_acc)) ? adc_data : min_acc;
    max_nx  = (adc_done && (adc_data > max_acc)) ? adc_data : max_acc;
  end

  // Scan period timer, parked at zero while scanning is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (!scan_en || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Scan sequencer with registered mux/ADC/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      scnt      <= '0;
      tcnt      <= '0;
      ov_lim    <= '0;
      uv_lim    <= '0;
      ov_acc    <= 1'b0;
      uv_acc    <= 1'b0;
      min_acc   <= '0;
      max_acc   <= '0;
      mux_sel   <= '0;
      adc_start <= 1'b0;
      ov_raw    <= 1'b0;
      uv_raw    <= 1'b0;
      min_v     <= '0;
      max_v     <= '0;
      scan_done <= 1'b0;
      adc_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (tick) begin
            ov_lim  <= ov_th;
            uv_lim  <= uv_th;
            idx     <= '0;
            mux_sel <= '0;
            scnt    <= '0;
            ov_acc  <= 1'b0;
            uv_acc  <= 1'b0;
            min_acc <= '1;
            max_acc <= '0;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (scnt == S_LAST) begin
            scnt      <= '0;
            adc_start <= 1'b1;
            state     <= ST_CONV;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_CONV: begin
          adc_start <= 1'b0;
          tcnt      <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (step) begin
            ov_acc  <= ov_nx;
            uv_acc  <= uv_nx;
            min_acc <= min_nx;
            max_acc <= max_nx;
            if (tmo_hit) begin
              adc_err <= 1'b1;
            end
            // Results publish together with the scan_done pulse.
            if (idx == C_LAST) begin
              ov_raw    <= ov_nx;
              uv_raw    <= uv_nx;
              min_v     <= min_nx;
              max_v     <= max_nx;
              scan_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              idx     <= idx + CW'(1);
              mux_sel <= idx + CW'(1);
              state   <= ST_SETTLE;
            end
          end else begin
            tcnt <= tcnt + WW'(1);
          end
        end
        ST_DONE: begin
          scan_done <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
